// File: rtl/line_bus_adapter.sv
// Cache-line to narrow RAM bus adapter: splits line fills and writebacks
// into BUS_WIDTH beats with a ram_ready wait-state handshake.
module line_bus_adapter #(
    parameter int LINE_WIDTH = 128,
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int BEAT_ORDER = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_ren,
    input  logic                  req_wen,
    input  logic [31:0]           req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic [LINE_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_read_enable,
    output logic                  ram_write_enable,
    output logic [31:0]           ram_address,
    output logic [BUS_WIDTH-1:0]  ram_in,
    input  logic [BUS_WIDTH-1:0]  ram_out,
    input  logic                  ram_ready
);

    localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFS   = $clog2(LINE_WIDTH / 8);
    localparam int DSH   = $clog2(DATA_WIDTH / 8);
    localparam int STEP  = BUS_WIDTH / DATA_WIDTH;
    localparam int IW    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [31:0]   LMSK = (32'd1 << OFS) - 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [CW-1:0]         beat;
    logic [31:0]           base;
    logic [LINE_WIDTH-1:0] wdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic [IW-1:0]         slot;
    logic                  last;
    logic                  accept;
    logic                  active;

    // Low bit index of the line slice owned by the current beat
    assign slot = (BEAT_ORDER == 0)
                ? IW'(LINE_WIDTH - BUS_WIDTH - int'(beat) * BUS_WIDTH)
                : IW'(int'(beat) * BUS_WIDTH);

    assign last   = (beat == LAST);
    assign accept = (state == IDLE) && (req_ren || req_wen);
    assign active = (state == READ) || (state == WRITE);

    assign ram_address = (base >> DSH) + 32'(beat) * 32'(STEP);
    assign rsp_rdata   = rdata;

    always_comb begin
        state_nx         = state;
        busy             = 1'b0;
        done             = 1'b0;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        ram_in           = '0;
        unique case (state)
            IDLE: begin
                busy = req_ren || req_wen;
                if (req_wen) begin
                    state_nx = WRITE;
                end else if (req_ren) begin
                    state_nx = READ;
                end
            end
            READ: begin
                busy            = 1'b1;
                ram_read_enable = 1'b1;
                if (ram_ready && last) begin
                    state_nx = DONE;
                end
            end
            WRITE: begin
                busy             = 1'b1;
                ram_write_enable = 1'b1;
                ram_in           = wdata[slot +: BUS_WIDTH];
                if (ram_ready && last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            beat  <= '0;
            base  <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                base  <= req_addr & ~LMSK;
                wdata <= req_wdata;
                beat  <= '0;
            end else if (active && ram_ready && !last) begin
                beat <= beat + CW'(1);
            end else if (state == DONE) begin
                beat <= '0;
            end
            if (state == READ && ram_ready) begin
                rdata[slot +: BUS_WIDTH] <= ram_out;
            end
        end
    end

endmodule
